// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver (and the matching transmitter):
// FSM state encoding, oversample ratio, sample points and the bit vote.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_t;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] SC_SAMPLE_A = 4'd7;
   localparam logic [3:0] SC_SAMPLE_B = 4'd8;
   localparam logic [3:0] SC_VOTE     = 4'd9;
   localparam logic [3:0] SC_LAST     = 4'(OVERSAMPLE - 1);

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: counts 0..TICK_DIV-1 and emits a one-cycle
// tick on the last count. A synchronous restart holds the count at zero
// and suppresses the tick, so the first tick comes TICK_DIV cycles after
// restart is released.
module uart_tick_gen #(
   parameter int TICK_DIV = 78
) (
   input  logic internal_clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   // divider counter, wraps at the last count or restarts on request
   always_ff @(posedge internal_clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (restart || (cnt_q == CNT_LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = !restart && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver with 16x oversampling and 3-sample majority
// vote, valid/ready output and frame/parity/overrun pulses.
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit per frame
// and makes o_parity_err live; without it o_parity_err stays 0).
//
// state  | meaning
// IDLE   | line idle, waiting for a 1->0 edge on rx_s
// START  | checking the start bit; a high vote is a false start
// DATA   | shifting DATA_BITS votes in, LSB first
// PARITY | checking the parity bit (only with the parity macro)
// STOP   | checking stop bit(s); commit or flag at the last vote
// BREAK  | frame error seen, waiting for the line to return high
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int TICK_DIV   = 78,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam logic       PAR_ODD   = (PARITY_ODD != 0);
   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t state_q, state_d;

   logic                 sync1_q, sync2_q, rx_prev_q;
   logic                 rx_s, fall;
   logic                 tick, tick_restart;
   logic [3:0]           sc_q;
   logic [1:0]           samp_q;
   logic                 vote, at_vote, at_end;
   logic [3:0]           bit_cnt_q;
   logic                 stop_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 fe_q, par_mis_q;

   logic shift_en, par_chk, bit_inc, stop_inc, fe_set, commit, fe_pulse;

   // two-flop synchroniser plus one delay flop for edge detection
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= i_rx;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   assign rx_s = sync2_q;
   assign fall = rx_prev_q & ~rx_s;

   // tick phase is pinned while idle so the start edge sets bit alignment
   assign tick_restart = (state_q == ST_IDLE);

   uart_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .internal_clk (i_clk),
      .rst          (i_rst),
      .restart      (tick_restart),
      .tick         (tick)
   );

   assign at_vote = tick && (sc_q == SC_VOTE);
   assign at_end  = tick && (sc_q == SC_LAST);
   assign vote    = majority3(samp_q[0], samp_q[1], rx_s);

   // oversample position within the bit and the two early samples
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sc_q   <= '0;
         samp_q <= '0;
      end else if (state_q == ST_IDLE) begin
         sc_q <= '0;
      end else if (tick) begin
         sc_q <= sc_q + 4'd1;
         if (sc_q == SC_SAMPLE_A) samp_q[0] <= rx_s;
         if (sc_q == SC_SAMPLE_B) samp_q[1] <= rx_s;
      end
   end

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and datapath strobes
   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      par_chk  = 1'b0;
      bit_inc  = 1'b0;
      stop_inc = 1'b0;
      fe_set   = 1'b0;
      commit   = 1'b0;
      fe_pulse = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall) state_d = ST_START;
         end
         ST_START: begin
            if (at_vote && vote) state_d = ST_IDLE;
            else if (at_end)     state_d = ST_DATA;
         end
         ST_DATA: begin
            if (at_vote) shift_en = 1'b1;
            if (at_end) begin
               if (bit_cnt_q == LAST_BIT) state_d = PAR_EN ? ST_PARITY : ST_STOP;
               else                       bit_inc = 1'b1;
            end
         end
         ST_PARITY: begin
            if (at_vote) par_chk = 1'b1;
            if (at_end)  state_d = ST_STOP;
         end
         ST_STOP: begin
            // the last stop bit decides at its vote so a new start edge
            // arriving right after the stop bit is still caught
            if (at_vote) begin
               if (stop_cnt_q == LAST_STOP) begin
                  if (fe_q || !vote) begin
                     fe_pulse = 1'b1;
                     state_d  = ST_BREAK;
                  end else begin
                     commit  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else if (!vote) begin
                  fe_set = 1'b1;
               end
            end else if (at_end) begin
               stop_inc = 1'b1;
            end
         end
         ST_BREAK: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // frame datapath: shift register, bit/stop counters, latched errors
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         fe_q       <= 1'b0;
         par_mis_q  <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         fe_q       <= 1'b0;
         par_mis_q  <= 1'b0;
      end else begin
         if (shift_en) shift_q    <= {vote, shift_q[DATA_BITS-1:1]};
         if (bit_inc)  bit_cnt_q  <= bit_cnt_q + 4'd1;
         if (stop_inc) stop_cnt_q <= 1'b1;
         if (fe_set)   fe_q       <= 1'b1;
         if (par_chk)  par_mis_q  <= vote ^ (^shift_q) ^ PAR_ODD;
      end
   end

   // output holding register, handshake and one-cycle error pulses
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_frame_err  <= fe_pulse;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
         if (commit) begin
            if (!o_valid || i_ready) begin
               o_data       <= shift_q;
               o_valid      <= 1'b1;
               o_parity_err <= par_mis_q & PAR_EN;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core with TICK_DIV = 4 (64 clocks per bit), 8 data bits,
// one stop bit, even parity when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid, fe, pe, ov, busy;

   always #5 clk = ~clk;

   uart_rx_core #(
      .TICK_DIV   (TICK_DIV),
      .DATA_BITS  (8),
      .STOP_BITS  (1),
      .PARITY_ODD (0)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx         (rx),
      .o_data       (data),
      .o_valid      (valid),
      .i_ready      (ready),
      .o_frame_err  (fe),
      .o_parity_err (pe),
      .o_overrun    (ov),
      .o_busy       (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_xfer   = 0;
   int n_fe     = 0;
   int n_pe     = 0;
   int n_ov     = 0;
   logic [7:0] got_q[$];

   // observe outputs mid-cycle: transfers and error pulses
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (valid && ready) begin
            got_q.push_back(data);
            n_xfer++;
         end
         if (fe) n_fe++;
         if (pe) n_pe++;
         if (ov) n_ov++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] last_got();
      if (got_q.size() == 0) return 32'hFFFF_FFFF;
      return {24'h0, got_q[$]};
   endfunction

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic v, input int clks);
      rx = v;
      hold(clks);
   endtask

   // start, 8 data bits LSB first, optional parity, one stop bit;
   // the line is left at the stop value
   task automatic send_frame(input logic [7:0] d, input logic stop_v,
                             input logic par_bit, input int clks);
      send_bit(1'b0, clks);
      for (int b = 0; b < 8; b++) send_bit(d[b], clks);
      if (PAR_EN) send_bit(par_bit, clks);
      send_bit(stop_v, clks);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop_v;
      int         exp_xfer;
      int         exp_fe;
   } vec_t;

   vec_t       vecs[5];
   logic [7:0] exp_q[$];
   int         x0, f0, p0, o0, exp_fe;
   logic [7:0] rd;
   logic       good;
   int         clks, gap;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1, 0};
      vecs[1] = '{8'h3C, 1'b0, 0, 1};
      vecs[2] = '{8'h00, 1'b1, 1, 0};
      vecs[3] = '{8'hFF, 1'b1, 1, 0};
      vecs[4] = '{8'h81, 1'b1, 1, 0};

      rx = 1'b1;
      ready = 1'b1;
      rst = 1'b1;
      hold(5);
      check("reset_valid", {31'b0, valid}, 0);
      check("reset_data", {24'b0, data}, 0);
      check("reset_busy", {31'b0, busy}, 0);
      check("reset_pulses", {29'b0, fe, pe, ov}, 0);
      rst = 1'b0;
      hold(10);

      // table-driven single frames
      for (int i = 0; i < 5; i++) begin
         x0 = n_xfer; f0 = n_fe; p0 = n_pe;
         send_frame(vecs[i].d, vecs[i].stop_v, ^vecs[i].d, BIT_CLKS);
         rx = 1'b1;
         hold(20);
         check($sformatf("vec%0d_xfer", i), n_xfer - x0, vecs[i].exp_xfer);
         check($sformatf("vec%0d_frame_err", i), n_fe - f0, vecs[i].exp_fe);
         check($sformatf("vec%0d_parity_err", i), n_pe - p0, 0);
         if (vecs[i].exp_xfer == 1)
            check($sformatf("vec%0d_data", i), last_got(), {24'h0, vecs[i].d});
         check($sformatf("vec%0d_busy", i), {31'b0, busy}, 0);
      end

      // glitch shorter than half a bit is a false start
      x0 = n_xfer; f0 = n_fe;
      rx = 1'b0;
      hold(10);
      check("glitch_busy_during", {31'b0, busy}, 1);
      hold(10);
      rx = 1'b1;
      hold(100);
      check("glitch_busy_after", {31'b0, busy}, 0);
      check("glitch_xfer", n_xfer - x0, 0);
      check("glitch_frame_err", n_fe - f0, 0);

      // bad stop followed by a long held-low line: one frame error only
      x0 = n_xfer; f0 = n_fe;
      send_frame(8'h3C, 1'b0, ^8'h3C, BIT_CLKS);
      hold(2000);
      check("break_busy_low", {31'b0, busy}, 1);
      rx = 1'b1;
      hold(20);
      check("break_frame_err", n_fe - f0, 1);
      check("break_xfer", n_xfer - x0, 0);
      check("break_busy_idle", {31'b0, busy}, 0);

      // overrun: consumer stalled across two back-to-back characters
      ready = 1'b0;
      hold(2);
      x0 = n_xfer; o0 = n_ov;
      send_frame(8'h55, 1'b1, ^8'h55, BIT_CLKS);
      send_frame(8'hC3, 1'b1, ^8'hC3, BIT_CLKS);
      rx = 1'b1;
      hold(20);
      check("ovr_pulse", n_ov - o0, 1);
      check("ovr_data_kept", {24'h0, data}, 32'h55);
      check("ovr_valid_held", {31'b0, valid}, 1);
      check("ovr_no_xfer", n_xfer - x0, 0);
      ready = 1'b1;
      hold(5);
      check("ovr_xfer", n_xfer - x0, 1);
      check("ovr_xfer_data", last_got(), 32'h55);
      check("ovr_valid_clear", {31'b0, valid}, 0);
      check("ovr_pulse_once", n_ov - o0, 1);

`ifdef UART_RX_PARITY_EN
      // even parity: 0x07 has three ones, so parity bit 1 is correct
      x0 = n_xfer; p0 = n_pe;
      send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS);
      rx = 1'b1;
      hold(20);
      check("par_bad_pulse", n_pe - p0, 1);
      check("par_bad_xfer", n_xfer - x0, 1);
      check("par_bad_data", last_got(), 32'h07);
      x0 = n_xfer; p0 = n_pe;
      send_frame(8'h07, 1'b1, 1'b1, BIT_CLKS);
      rx = 1'b1;
      hold(20);
      check("par_good_pulse", n_pe - p0, 0);
      check("par_good_xfer", n_xfer - x0, 1);
`endif

      // reset in the middle of data bit 4 of 0xFF, then a clean 0x12
      x0 = n_xfer; f0 = n_fe;
      send_bit(1'b0, BIT_CLKS);
      for (int b = 0; b < 4; b++) send_bit(1'b1, BIT_CLKS);
      hold(30);
      rst = 1'b1;
      hold(3);
      check("rst_mid_busy", {31'b0, busy}, 0);
      check("rst_mid_valid", {31'b0, valid}, 0);
      rst = 1'b0;
      hold(BIT_CLKS * 5);
      send_frame(8'h12, 1'b1, ^8'h12, BIT_CLKS);
      rx = 1'b1;
      hold(20);
      check("rst_mid_xfer", n_xfer - x0, 1);
      check("rst_mid_data", last_got(), 32'h12);
      check("rst_mid_frame_err", n_fe - f0, 0);

      // random characters, random gaps and +/-1.5 % bit length
      got_q.delete();
      exp_q.delete();
      exp_fe = 0;
      f0 = n_fe; p0 = n_pe;
      for (int i = 0; i < 24; i++) begin
         rd   = 8'($urandom);
         good = ($urandom_range(0, 5) != 0);
         clks = $urandom_range(BIT_CLKS - 1, BIT_CLKS + 1);
         gap  = good ? $urandom_range(0, 30) : $urandom_range(10, 30);
         send_frame(rd, good, ^rd, clks);
         rx = 1'b1;
         hold(gap);
         if (good) exp_q.push_back(rd);
         else      exp_fe++;
      end
      hold(50);
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("rand_data%0d", i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
      check("rand_frame_err", n_fe - f0, exp_fe);
      check("rand_parity_err", n_pe - p0, 0);
      check("rand_busy_end", {31'b0, busy}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
